// File: rtl/ac_regbank.sv
// Bank of 2**AW accumulators with in-place ALU-style ops and registered status flags.
// Define AC_SHADOW_EN to add save/restore ports backed by a shadow copy of registers and flags.
module ac_regbank #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    wsel,
  input  logic [WIDTH-1:0] Din,
  input  logic [AW-1:0]    rsel_a,
  input  logic [AW-1:0]    rsel_b,
`ifdef AC_SHADOW_EN
  input  logic             save,
  input  logic             restore,
`endif
  output logic [WIDTH-1:0] Dout_a,
  output logic [WIDTH-1:0] Dout_b,
  output logic             zero,
  output logic             neg,
  output logic             carry
);

  localparam int NREG = 1 << AW;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_CLR  = 3'b010;
  localparam logic [2:0] OP_INC  = 3'b011;
  localparam logic [2:0] OP_DEC  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_SHR  = 3'b110;
  localparam logic [2:0] OP_MOV  = 3'b111;

  logic [WIDTH-1:0] regs [NREG];
  logic [WIDTH-1:0] old_val;
  logic [WIDTH-1:0] result;
  logic             carry_next;
  logic             write_en;

  assign old_val = regs[wsel];
  assign Dout_a  = regs[rsel_a];
  assign Dout_b  = regs[rsel_b];

  always_comb begin
    result     = '0;
    carry_next = carry;
    write_en   = (op != OP_NOP);
    case (op)
      OP_LOAD: result = Din;
      OP_CLR:  result = '0;
      OP_INC: begin
        result     = old_val + 1'b1;
        carry_next = &old_val;
      end
      OP_DEC: begin
        result     = old_val - 1'b1;
        carry_next = ~|old_val;
      end
      OP_SHL: begin
        result     = {old_val[WIDTH-2:0], 1'b0};
        carry_next = old_val[WIDTH-1];
      end
      OP_SHR: begin
        result     = {1'b0, old_val[WIDTH-1:1]};
        carry_next = old_val[0];
      end
      OP_MOV:  result = regs[rsel_a];
      default: result = '0;
    endcase
  end

`ifdef AC_SHADOW_EN
  logic [WIDTH-1:0] shadow_regs [NREG];
  logic             shadow_zero, shadow_neg, shadow_carry;

  // Shadow captures pre-op state; a simultaneous restore leaves it untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_zero  <= 1'b0;
      shadow_neg   <= 1'b0;
      shadow_carry <= 1'b0;
    end else if (save && !restore) begin
      shadow_zero  <= zero;
      shadow_neg   <= neg;
      shadow_carry <= carry;
    end
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          regs[gi] <= '0;
`ifdef AC_SHADOW_EN
        end else if (restore) begin
          regs[gi] <= shadow_regs[gi];
`endif
        end else if (write_en && (wsel == AW'(gi))) begin
          regs[gi] <= result;
        end
      end

`ifdef AC_SHADOW_EN
      always_ff @(posedge clk) begin
        if (rst) begin
          shadow_regs[gi] <= '0;
        end else if (save && !restore) begin
          shadow_regs[gi] <= regs[gi];
        end
      end
`endif
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      zero  <= 1'b0;
      neg   <= 1'b0;
      carry <= 1'b0;
`ifdef AC_SHADOW_EN
    end else if (restore) begin
      zero  <= shadow_zero;
      neg   <= shadow_neg;
      carry <= shadow_carry;
`endif
    end else if (write_en) begin
      zero  <= (result == '0);
      neg   <= result[WIDTH-1];
      carry <= carry_next;
    end
  end

endmodule

// File: doc/ac_regbank.md
Name: ac_regbank

Overview:
- Parametrised successor to the single AC register: a bank of 2**AW accumulators, each WIDTH bits wide.
- Supports in-place operations: load, clear, increment, decrement, shift left/right and register-to-register move.
- Produces status flags for the controller.
- Sits between the ALU result bus and the ALU operand inputs; the controller drives op/select lines each cycle.

Parameters:
- WIDTH, 8, data width of each accumulator
- AW, 2, register-select width; bank holds 2**AW registers

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- op  input  3  operation code, applied to register wsel
- wsel  input  AW  destination register index
- Din  input  WIDTH  load data, from ALU
- rsel_a  input  AW  read port A index; also MOV source
- rsel_b  input  AW  read port B index
- Dout_a  output  WIDTH  contents of reg[rsel_a], combinational read
- Dout_b  output  WIDTH  contents of reg[rsel_b], combinational read
- zero  output  1  registered: last written result == 0
- neg  output  1  registered: MSB of last written result
- carry  output  1  registered carry/borrow/shifted-out bit

Behaviour:
- Reset (rst=1 at posedge): all registers 0; zero=0, neg=0, carry=0. Overrides everything else, including mid-sequence operations.
- Op codes; result R is written to reg[wsel] at the posedge:
  - 000 NOP: nothing written; all flags hold.
  - 001 LOAD: R=Din; carry holds.
  - 010 CLR: R=0; carry holds.
  - 011 INC: R=reg[wsel]+1 mod 2**WIDTH; carry=1 iff old value all-ones (wrap to 0).
  - 100 DEC: R=reg[wsel]-1 mod 2**WIDTH; carry=1 iff old value 0 (borrow, wrap to all-ones).
  - 101 SHL: R={reg[wsel][WIDTH-2:0],0}; carry=old MSB.
  - 110 SHR: R={0,reg[wsel][WIDTH-1:1]} (logical); carry=old LSB.
  - 111 MOV: R=reg[rsel_a], sampled before the edge; carry holds. wsel==rsel_a is legal and a no-op on data; flags still update.
- Flags: on every non-NOP op, zero=(R==0) and neg=R[WIDTH-1], registered the same edge as the write.
- Latency: write visible on Dout_a/Dout_b the cycle after the edge. No internal bypass: reading wsel in the same cycle returns the old value.
- Read ports are independent; rsel_a==rsel_b is legal and both ports return the same value.
- Only one register is written per cycle; unselected registers always hold.
- All arithmetic is unsigned and modular within WIDTH bits; no saturation.

Optional Feature:
- Macro: AC_SHADOW_EN
- With macro:
  - Adds ports `save` (input, 1) and `restore` (input, 1).
  - Adds a shadow copy of all 2**AW registers plus the zero/neg/carry flags; shadow resets to 0.
  - save=1: shadow <= current registers and flags (pre-op values); the op in the same cycle still executes normally.
  - restore=1: registers and flags <= shadow; op is ignored that cycle.
  - save and restore together: restore wins; shadow unchanged.
  - Priority: rst > restore > save/op.
- Without macro: no save/restore ports, no shadow storage; behaviour is exactly as above.

Test Plan:
- Reset, then LOAD 8'hA5 into reg2, rsel_a=2 → next cycle Dout_a=8'hA5, zero=0, neg=1, carry=0. Apply rst mid-stream → all Dout=0, flags 0.
- LOAD 8'hFF to reg1, then INC reg1 → reg1=8'h00, zero=1, carry=1. Then DEC reg1 → 8'hFF, neg=1, carry=1. Then DEC again → 8'hFE, carry=0.
- LOAD 8'h81 to reg0; SHL → 8'h02, carry=1. SHR → 8'h01, carry=0. SHR → 8'h00, carry=1, zero=1.
- LOAD reg3=8'h3C; MOV wsel=0, rsel_a=3 → reg0=8'h3C. In the same cycle as a LOAD to reg0, rsel_b=0 still reads the old value.
- NOP after INC wrap → zero/neg/carry unchanged. LOAD 8'h00 after carry=1 → zero=1, carry stays 1.
- (AC_SHADOW_EN) reg0=8'h11, save with INC reg0 → reg0=8'h12. LOAD reg0=8'h77, then restore with op=LOAD 8'h55 → reg0=8'h11 and flags equal the values at save time.
